// File: rtl/layer_mac.sv
// layer_mac: time-multiplexed fully connected layer.
//   y[j] = act(round(sum_i x[i]*M[i*column_size+j] + b[j]) >> shift)
// Outputs are computed in groups of `lanes` outputs.
// Each group takes one LOAD cycle (bias), row_size MAC cycles and one ACT cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  request a computation (sampled only when idle)
//   x      signed inputs, latched when start is accepted
//   M      signed weights, M[i*column_size+j] links x[i] to y[j]; hold stable while busy
//   b      signed bias per output; hold stable while busy
//   y      registered signed outputs
//   busy   high from start acceptance until done rises
//   done   high once all y are valid, until the next start is accepted
module layer_mac #(
  parameter int bits        = 8,
  parameter int max_bits    = 20,
  parameter int shift       = 0,
  parameter int row_size    = 10,
  parameter int column_size = 10,
  parameter int lanes       = 1,
  parameter int relu        = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [bits-1:0]     x [0:row_size-1],
  input  logic signed [bits-1:0]     M [0:row_size*column_size-1],
  input  logic signed [max_bits-1:0] b [0:column_size-1],
  output logic signed [bits-1:0]     y [0:column_size-1],
  output logic                       busy,
  output logic                       done
);

  localparam int G   = column_size / lanes;
  localparam int GW  = (G > 1) ? $clog2(G) : 1;
  localparam int IW  = (row_size > 1) ? $clog2(row_size) : 1;
  localparam int MIW = (row_size * column_size > 1) ? $clog2(row_size * column_size) : 1;
  localparam int YW  = (column_size > 1) ? $clog2(column_size) : 1;

  // The inner conditional keeps the shift amount non-negative when shift is 0.
  localparam int RND_I = (shift > 0) ? (1 << ((shift > 0) ? shift - 1 : 0)) : 0;
  localparam logic signed [max_bits:0] RND    = (max_bits+1)'(RND_I);
  localparam logic signed [max_bits:0] SAT_HI = (max_bits+1)'((1 << (bits - 1)) - 1);
  localparam logic signed [max_bits:0] SAT_LO = (max_bits+1)'(-(1 << (bits - 1)));

  typedef enum logic [1:0] {IDLE, LOAD, MAC, ACT} state_t;

  state_t                     state_q, state_d;
  logic [GW-1:0]              g_q, g_d;
  logic [IW-1:0]              i_q, i_d;
  logic signed [bits-1:0]     x_q [0:row_size-1];
  logic signed [bits-1:0]     x_d [0:row_size-1];
  logic signed [max_bits-1:0] acc_q [0:lanes-1];
  logic signed [max_bits-1:0] acc_d [0:lanes-1];
  logic signed [bits-1:0]     y_q [0:column_size-1];
  logic signed [bits-1:0]     y_d [0:column_size-1];
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  // Per-lane datapath terms.
  logic signed [max_bits-1:0] term  [0:lanes-1];
  logic signed [max_bits-1:0] b_sel [0:lanes-1];
  logic signed [bits-1:0]     act_v [0:lanes-1];
  logic [YW-1:0]              y_idx [0:lanes-1];

  // Round half up, optionally clamp negatives to zero, then saturate to bits.
  // The one extra bit of headroom keeps the rounding add from overflowing.
  function automatic logic signed [bits-1:0] act_out(input logic signed [max_bits-1:0] a);
    logic signed [max_bits:0] t;
    t = {a[max_bits-1], a};
    t = t + RND;
    t = t >>> shift;
    if (relu != 0 && t < 0) t = '0;
    if (t > SAT_HI)      t = SAT_HI;
    else if (t < SAT_LO) t = SAT_LO;
    return t[bits-1:0];
  endfunction

  for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
    logic [MIW-1:0]           m_idx;
    logic signed [2*bits-1:0] prod;
    assign m_idx       = MIW'(int'(i_q) * column_size + int'(g_q) * lanes + gi);
    assign y_idx[gi]   = YW'(int'(g_q) * lanes + gi);
    assign prod        = x_q[i_q] * M[m_idx];
    assign term[gi]    = {{(max_bits - 2*bits){prod[2*bits-1]}}, prod};
    assign b_sel[gi]   = b[y_idx[gi]];
    assign act_v[gi]   = act_out(acc_q[gi]);
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    i_d     = i_q;
    x_d     = x_q;
    acc_d   = acc_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          g_d     = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int l = 0; l < lanes; l++) acc_d[l] = b_sel[l];
        i_d     = '0;
        state_d = MAC;
      end
      MAC: begin
        // Accumulation wraps modulo 2^max_bits.
        for (int l = 0; l < lanes; l++) acc_d[l] = acc_q[l] + term[l];
        if (i_q == IW'(row_size - 1)) state_d = ACT;
        else                          i_d     = i_q + 1'b1;
      end
      ACT: begin
        for (int l = 0; l < lanes; l++) y_d[y_idx[l]] = act_v[l];
        if (g_q == GW'(G - 1)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          g_d     = g_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      g_q     <= '0;
      i_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int k = 0; k < row_size; k++)    x_q[k]   <= '0;
      for (int k = 0; k < lanes; k++)       acc_q[k] <= '0;
      for (int k = 0; k < column_size; k++) y_q[k]   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      i_q     <= i_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_layer_mac.sv
// Bench for layer_mac.
// It runs five instances side by side on shared stimulus:
//   0: lanes=2 relu=1 shift=0
//   1: lanes=2 relu=0 shift=0
//   2: lanes=2 relu=0 shift=2
//   3: lanes=1 relu=1 shift=0
//   4: lanes=4 relu=1 shift=0
module tb_layer_mac;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic signed [7:0]  x_t [0:1];
  logic signed [7:0]  m_t [0:7];
  logic signed [19:0] b_t [0:3];
  logic signed [7:0]  y_o [0:NI-1][0:3];
  logic [NI-1:0]      busy_v;
  logic [NI-1:0]      done_v;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    logic signed [7:0] y_w [0:3];
    layer_mac #(
      .bits(8), .max_bits(20), .shift((gi == 2) ? 2 : 0), .row_size(2), .column_size(4),
      .lanes((gi == 3) ? 1 : ((gi == 4) ? 4 : 2)), .relu((gi == 1 || gi == 2) ? 0 : 1)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start), .x(x_t), .M(m_t), .b(b_t),
      .y(y_w), .busy(busy_v[gi]), .done(done_v[gi])
    );
    for (genvar gj = 0; gj < 4; gj++) begin : g_y
      assign y_o[gi][gj] = y_w[gj];
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_lat(input int k);
    return (k == 3) ? 16 : ((k == 4) ? 4 : 8);
  endfunction

  // Reference model: wrapping 20-bit accumulate, round half up, optional ReLU, saturate.
  function automatic int model_y(input int k, input int j);
    int a, sh, rl;
    sh = (k == 2) ? 2 : 0;
    rl = (k == 1 || k == 2) ? 0 : 1;
    a = int'(b_t[j]);
    for (int i = 0; i < 2; i++) a += int'(x_t[i]) * int'(m_t[i*4+j]);
    a = (a <<< 12) >>> 12;
    if (sh > 0) a = (a + (1 << (sh - 1))) >>> sh;
    if (rl != 0 && a < 0) a = 0;
    if (a > 127) a = 127;
    if (a < -128) a = -128;
    return a;
  endfunction

  task automatic set_vec(input int x0, input int x1, input int mv, input int b0,
                         input int b1, input int b2, input int b3);
    x_t[0] = 8'(x0);
    x_t[1] = 8'(x1);
    for (int i = 0; i < 8; i++) m_t[i] = 8'(mv);
    b_t[0] = 20'(b0);
    b_t[1] = 20'(b1);
    b_t[2] = 20'(b2);
    b_t[3] = 20'(b3);
  endtask

  task automatic set_rand();
    for (int i = 0; i < 2; i++) x_t[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) m_t[i] = 8'($urandom_range(0, 255));
    for (int j = 0; j < 4; j++) b_t[j] = 20'($urandom_range(0, 2000) - 1000);
  endtask

  task automatic run(input string name, input bit poke_start, input bit abort);
    int lat [NI];
    int cyc;
    bit all_done;
    for (int k = 0; k < NI; k++)
      for (int j = 0; j < 4; j++) exp_q.push_back(model_y(k, j));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s/busy_on%0d", name, k), int'(busy_v[k]), 1);
      check($sformatf("%s/done_off%0d", name, k), int'(done_v[k]), 0);
      lat[k] = -1;
    end
    cyc = 0;
    all_done = 1'b0;
    while (!all_done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      start = (poke_start && cyc == 3);
      if (abort && cyc == 3) begin
        reset = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
          check($sformatf("%s/abort_busy%0d", name, k), int'(busy_v[k]), 0);
          check($sformatf("%s/abort_done%0d", name, k), int'(done_v[k]), 0);
          for (int j = 0; j < 4; j++)
            check($sformatf("%s/abort_y%0d_%0d", name, k, j), int'(y_o[k][j]), 0);
        end
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        $display("run %s: aborted by reset at cycle %0d", name, cyc);
        return;
      end
      all_done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (done_v[k] && lat[k] < 0) lat[k] = cyc;
        if (lat[k] < 0) all_done = 1'b0;
      end
    end
    start = 1'b0;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("%s/latency%0d", name, k), lat[k], exp_lat(k));
      for (int j = 0; j < 4; j++)
        check($sformatf("%s/y%0d_%0d", name, k, j), int'(y_o[k][j]), exp_q.pop_front());
    end
    $display("run %s: lat=%0d/%0d/%0d y0=[%0d %0d %0d %0d] y2=[%0d %0d %0d %0d]", name,
             lat[0], lat[3], lat[4], y_o[0][0], y_o[0][1], y_o[0][2], y_o[0][3],
             y_o[2][0], y_o[2][1], y_o[2][2], y_o[2][3]);
  endtask

  initial begin
    set_vec(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset/busy%0d", k), int'(busy_v[k]), 0);
      check($sformatf("reset/done%0d", k), int'(done_v[k]), 0);
      for (int j = 0; j < 4; j++)
        check($sformatf("reset/y%0d_%0d", k, j), int'(y_o[k][j]), 0);
    end
    $display("run reset: idle state observed");
    @(negedge clk);
    reset = 1'b1;

    set_vec(2, 3, 1, 0, 0, 0, 0);
    run("basic", 1'b0, 1'b0);
    set_vec(2, 3, 1, 0, -20, 4, -5);
    run("bias", 1'b0, 1'b0);
    set_vec(127, 127, 127, 0, 0, 0, 0);
    run("sat_pos", 1'b0, 1'b0);
    set_vec(-128, -128, 127, 0, 0, 0, 0);
    run("sat_neg", 1'b0, 1'b0);
    set_vec(0, 0, 5, 6, -6, 7, -7);
    run("round", 1'b0, 1'b0);
    set_vec(2, 3, 1, 0, -20, 4, -5);
    run("restart_ignored", 1'b1, 1'b0);
    set_rand();
    run("abort", 1'b0, 1'b1);
    set_rand();
    run("after_abort", 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      set_rand();
      run($sformatf("rand%0d", n), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
